// File: rtl/vend_pkg.sv
// Shared definitions for the vending payout path: coin values, denomination
// select codes and the change-dispenser state encoding.
package vend_pkg;

    localparam logic [3:0] COIN_1 = 4'd1;
    localparam logic [3:0] COIN_2 = 4'd2;
    localparam logic [3:0] COIN_5 = 4'd5;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_1    = 2'b01,
        SEL_2    = 2'b10,
        SEL_5    = 2'b11
    } coin_sel_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT_ACK,
        S_DONE,
        S_FAULT
    } disp_state_t;

    function automatic logic [3:0] coin_value(input coin_sel_t sel);
        case (sel)
            SEL_1:   coin_value = COIN_1;
            SEL_2:   coin_value = COIN_2;
            SEL_5:   coin_value = COIN_5;
            default: coin_value = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counters. A host load always beats a same-cycle
// payout decrement, and a counter already at zero never wraps.
module coin_inventory
    import vend_pkg::*;
#(
    parameter int INV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [1:0]       load_sel,
    input  logic [INV_W-1:0] load_val,
    input  logic             dec_en,
    input  logic [1:0]       dec_sel,
    output logic [INV_W-1:0] inv_5,
    output logic [INV_W-1:0] inv_2,
    output logic [INV_W-1:0] inv_1
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_5 <= '0;
            inv_2 <= '0;
            inv_1 <= '0;
        end else begin
            if (load_en && load_sel == SEL_5)
                inv_5 <= load_val;
            else if (dec_en && dec_sel == SEL_5 && inv_5 != '0)
                inv_5 <= inv_5 - INV_W'(1);

            if (load_en && load_sel == SEL_2)
                inv_2 <= load_val;
            else if (dec_en && dec_sel == SEL_2 && inv_2 != '0)
                inv_2 <= inv_2 - INV_W'(1);

            if (load_en && load_sel == SEL_1)
                inv_1 <= load_val;
            else if (dec_en && dec_sel == SEL_1 && inv_1 != '0)
                inv_1 <= inv_1 - INV_W'(1);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Payout engine: pays a 0-15 rupee change amount greedily as 5/2/1 coins,
// pulsing one hopper solenoid per coin and waiting for the sensor acknowledge.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int TIMEOUT = 255,
    parameter int INV_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [3:0]       req_amount,
    output logic             req_ready,
    output logic             eject_5,
    output logic             eject_2,
    output logic             eject_1,
    input  logic             coin_sent,
    input  logic             load_en,
    input  logic [1:0]       load_sel,
    input  logic [INV_W-1:0] load_val,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [3:0]       remaining,
    output logic [INV_W-1:0] inv_5,
    output logic [INV_W-1:0] inv_2,
    output logic [INV_W-1:0] inv_1
);

    // state      | meaning
    // S_IDLE     | ready for a request
    // S_SELECT   | choose largest coin that fits and is stocked
    // S_EJECT    | solenoid pulse for PULSE_W cycles
    // S_WAIT_ACK | wait for coin_sent, bounded by TIMEOUT
    // S_DONE     | one-cycle done pulse
    // S_FAULT    | payout abandoned, remaining keeps the shortfall

    localparam int PW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    disp_state_t   state;
    coin_sel_t     sel;
    coin_sel_t     pick;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic          coin_dec;

    assign coin_dec = (state == S_WAIT_ACK) && coin_sent;

    coin_inventory #(.INV_W(INV_W)) u_inv (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .load_sel (load_sel),
        .load_val (load_val),
        .dec_en   (coin_dec),
        .dec_sel  (sel),
        .inv_5    (inv_5),
        .inv_2    (inv_2),
        .inv_1    (inv_1)
    );

    // Greedy choice, no backtracking: a stocked larger coin is always taken.
    always_comb begin
        pick = SEL_NONE;
        if (remaining >= COIN_5 && inv_5 != '0)
            pick = SEL_5;
        else if (remaining >= COIN_2 && inv_2 != '0)
            pick = SEL_2;
        else if (remaining >= COIN_1 && inv_1 != '0)
            pick = SEL_1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            sel       <= SEL_NONE;
            pcnt      <= '0;
            tcnt      <= '0;
            remaining <= '0;
            fault     <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            eject_5   <= 1'b0;
            eject_2   <= 1'b0;
            eject_1   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        remaining <= req_amount;
                        fault     <= 1'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (remaining == 4'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (pick != SEL_NONE) begin
                        sel     <= pick;
                        pcnt    <= PW'(PULSE_W - 1);
                        eject_5 <= (pick == SEL_5);
                        eject_2 <= (pick == SEL_2);
                        eject_1 <= (pick == SEL_1);
                        state   <= S_EJECT;
                    end else begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end
                end
                S_EJECT: begin
                    if (pcnt == '0) begin
                        eject_5 <= 1'b0;
                        eject_2 <= 1'b0;
                        eject_1 <= 1'b0;
                        tcnt    <= TW'(TIMEOUT);
                        state   <= S_WAIT_ACK;
                    end else begin
                        pcnt <= pcnt - PW'(1);
                    end
                end
                S_WAIT_ACK: begin
                    // An acknowledge arriving on the last allowed cycle still counts.
                    if (coin_sent) begin
                        remaining <= remaining - coin_value(sel);
                        state     <= S_SELECT;
                    end else if (tcnt == '0) begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                S_DONE, S_FAULT: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    eject_5   <= 1'b0;
                    eject_2   <= 1'b0;
                    eject_1   <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: directed payouts push expected
// completions; a negedge monitor pops and compares on each done/fault.
module tb_change_dispenser;
    import vend_pkg::*;

    localparam int PULSE_W = 4;
    localparam int TIMEOUT = 12;
    localparam int INV_W   = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic [3:0]       req_amount = 4'd0;
    logic             req_ready;
    logic             eject_5, eject_2, eject_1;
    logic             coin_sent;
    logic             load_en = 1'b0;
    logic [1:0]       load_sel = 2'b00;
    logic [INV_W-1:0] load_val = '0;
    logic             busy, done, fault;
    logic [3:0]       remaining;
    logic [INV_W-1:0] inv_5, inv_2, inv_1;

    logic hop_coin = 1'b0;
    logic man_coin = 1'b0;
    logic hopper_en = 1'b0;
    assign coin_sent = hop_coin | man_coin;

    change_dispenser #(.PULSE_W(PULSE_W), .TIMEOUT(TIMEOUT), .INV_W(INV_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .eject_5    (eject_5),
        .eject_2    (eject_2),
        .eject_1    (eject_1),
        .coin_sent  (coin_sent),
        .load_en    (load_en),
        .load_sel   (load_sel),
        .load_val   (load_val),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .remaining  (remaining),
        .inv_5      (inv_5),
        .inv_2      (inv_2),
        .inv_1      (inv_1)
    );

    always #5 clk = ~clk;

    // seq: eject order as decimal digits, e.g. 521; -1 fields are not checked
    typedef struct {
        bit is_fault;
        int rem;
        int i5;
        int i2;
        int i1;
        int seq;
        int lat;
        int flat;
        int nbusy;
        int fej;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, n_req = 0, n_acc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(bit f, int rem, int i5, int i2, int i1, int seq,
                                int lat, int flat, int nbusy, int fej);
        exp_t e;
        e.is_fault = f; e.rem = rem; e.i5 = i5; e.i2 = i2; e.i1 = i1; e.seq = seq;
        e.lat = lat; e.flat = flat; e.nbusy = nbusy; e.fej = fej;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Hopper model: one coin_sent pulse a few cycles after each eject pulse.
    always begin
        @(negedge clk);
        if (hopper_en && (eject_5 || eject_2 || eject_1)) begin
            for (int i = 0; i < 100 && (eject_5 || eject_2 || eject_1); i++) @(negedge clk);
            repeat (2) @(posedge clk);
            #1 hop_coin = 1'b1;
            @(posedge clk);
            #1 hop_coin = 1'b0;
        end
    end

    // Monitor
    int ej_w = 0, seq_v = 0, acc_cyc = 0, fall_cyc = 0, first_ej = 0, nbusy = 0;
    bit fault_q = 1'b0;
    exp_t me;

    always @(negedge clk) begin
        if (reset) begin
            ej_w = 0; seq_v = 0; nbusy = 0; fault_q = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                n_acc++; acc_cyc = cyc; seq_v = 0; nbusy = 0;
            end
            if (busy) nbusy++;
            if (eject_5 || eject_2 || eject_1) begin
                if (ej_w == 0) begin
                    if (seq_v == 0) first_ej = cyc;
                    seq_v = seq_v * 10 + (eject_5 ? 5 : (eject_2 ? 2 : 1));
                end
                ej_w++;
            end else if (ej_w != 0) begin
                check("eject_width", ej_w, PULSE_W);
                ej_w = 0;
                fall_cyc = cyc;
            end
            if (done || (fault && !fault_q)) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_completion: got done=%0b fault=%0b, expected no completion (cycle %0d)",
                             done, fault, cyc);
                end else begin
                    me = sb.pop_front();
                    check("completion_is_fault", int'(fault), int'(me.is_fault));
                    check("completion_is_done", int'(done), int'(!me.is_fault));
                    check("remaining", int'(remaining), me.rem);
                    check("inv_5", int'(inv_5), me.i5);
                    check("inv_2", int'(inv_2), me.i2);
                    check("inv_1", int'(inv_1), me.i1);
                    check("eject_sequence", seq_v, me.seq);
                    if (me.lat >= 0)   check("done_latency", cyc - acc_cyc, me.lat);
                    if (me.flat >= 0)  check("timeout_latency", cyc - fall_cyc, me.flat);
                    if (me.nbusy >= 0) check("busy_cycles", nbusy, me.nbusy);
                    if (me.fej >= 0)   check("first_eject_latency", first_ej - acc_cyc, me.fej);
                end
            end
            fault_q = fault;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] s, input int v);
        load_en = 1'b1; load_sel = s; load_val = INV_W'(v);
        tick();
        load_en = 1'b0; load_sel = 2'b00;
    endtask

    task automatic push_req(input int amt, input exp_t e);
        for (int w = 0; w < 100 && !req_ready; w++) tick();
        sb.push_back(e);
        n_req++;
        req_valid = 1'b1; req_amount = 4'(amt);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got %0d payouts outstanding after %0d cycles, expected 0", name, sb.size(), budget);
            sb.delete();
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", int'(req_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_fault", int'(fault), 0);
        check("reset_eject", int'({eject_5, eject_2, eject_1}), 0);
        check("reset_remaining", int'(remaining), 0);
        check("reset_inv", int'(inv_5) + int'(inv_2) + int'(inv_1), 0);
        reset = 1'b0;
        tick();

        // 8 = 5+2+1 from full stock
        hopper_en = 1'b1;
        load(SEL_5, 3); load(SEL_2, 3); load(SEL_1, 3);
        push_req(8, mk(0, 0, 2, 2, 2, 521, -1, -1, -1, 2));
        wait_idle("pay_8", 200);

        // zero amount: done two cycles after accept, no eject
        push_req(0, mk(0, 0, 2, 2, 2, 0, 2, -1, 2, -1));
        wait_idle("pay_0", 50);

        // greedy 3 with no 1-coins: one 2-coin then stuck on 1
        load(SEL_5, 0); load(SEL_2, 3); load(SEL_1, 0);
        push_req(3, mk(1, 1, 0, 2, 0, 2, -1, -1, -1, 2));
        wait_idle("pay_3_short", 100);

        // hopper never acknowledges
        hopper_en = 1'b0;
        load(SEL_5, 1);
        push_req(5, mk(1, 5, 1, 2, 0, 5, -1, TIMEOUT + 1, -1, 2));
        wait_idle("pay_5_timeout", 200);

        // request pulsed while busy must be dropped
        hopper_en = 1'b1;
        load(SEL_1, 5);
        push_req(3, mk(0, 0, 1, 1, 4, 21, -1, -1, -1, 2));
        repeat (3) tick();
        req_valid = 1'b1; req_amount = 4'd9;
        repeat (3) tick();
        req_valid = 1'b0;
        wait_idle("pay_3_busy_req", 200);

        // load of the 2-counter on the same edge as its decrement
        hopper_en = 1'b0;
        load(SEL_2, 3); load(SEL_5, 0); load(SEL_1, 0);
        push_req(2, mk(0, 0, 0, 7, 0, 2, -1, -1, -1, 2));
        for (int i = 0; i < 50 && !eject_2; i++) tick();
        for (int i = 0; i < 50 && eject_2; i++) tick();
        man_coin = 1'b1; load_en = 1'b1; load_sel = SEL_2; load_val = INV_W'(7);
        tick();
        man_coin = 1'b0; load_en = 1'b0; load_sel = 2'b00;
        wait_idle("pay_2_load_collide", 50);

        // reset while ejecting
        hopper_en = 1'b1;
        load(SEL_5, 2);
        push_req(5, mk(0, 0, 1, 7, 0, 5, -1, -1, -1, 2));
        for (int i = 0; i < 50 && !eject_5; i++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_eject_seen", 1, 1 - int'(sb.size() == 0));
        check("midreset_eject", int'({eject_5, eject_2, eject_1}), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_req_ready", int'(req_ready), 1);
        sb.delete();
        tick(); tick();
        reset = 1'b0;
        repeat (8) tick();
        check("post_reset_req_ready", int'(req_ready), 1);
        check("post_reset_busy", int'(busy), 0);
        check("post_reset_fault", int'(fault), 0);
        check("post_reset_remaining", int'(remaining), 0);
        check("post_reset_inv_5", int'(inv_5), 0);
        check("post_reset_inv_2", int'(inv_2), 0);
        check("post_reset_inv_1", int'(inv_1), 0);

        check("accepted_requests", n_acc, n_req);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
